// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encodings and small op-decode helpers.
// Build option MULDIV_FAST_MUL_EN: when defined, MULT/MULTU complete in one
// combinational product cycle plus FIN (busy for 2 cycles); divide is unchanged.
// When undefined, multiply is the iterative shift-add over WIDTH cycles.
package muldiv_unit_pkg;

  // Operation encodings on the op input
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  // FSM states (MD_S_ prefix keeps them apart from the op names)
  typedef enum logic [1:0] {
    MD_S_IDLE = 2'b00,
    MD_S_MUL  = 2'b01,
    MD_S_DIV  = 2'b10,
    MD_S_FIN  = 2'b11
  } md_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// Handshake: start is a request that the unit accepts only at an edge where it
// is idle (busy low) and flush is low; there is no ready and no queueing, so
// the requester must stall on busy and re-issue nothing while busy is high.
// done pulses for exactly the cycle in which hi/lo show a new MULT/DIV result.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic                          start;
  logic [2:0]                    op;
  logic [WIDTH-1:0]              src_a;
  logic [WIDTH-1:0]              src_b;
  logic                          flush;
  logic                          busy;
  logic                          done;
  logic [WIDTH-1:0]              hi;
  logic [WIDTH-1:0]              lo;
  muldiv_unit_pkg::md_state_e    state;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, done, hi, lo, state
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, done, hi, lo, state
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath.
// Multiply (div_mode_i=0): shift-add; hi accumulates the partial product, lo
// holds the remaining multiplier bits and receives product bits from the top.
// Divide (div_mode_i=1): restoring; hi is the partial remainder, lo shifts the
// dividend out of its top and the quotient bit into its bottom.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_mode_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ok;

  // Single-bit step for either mode
  always_comb begin
    mul_sum   = lo_i[0] ? ({1'b0, hi_i} + {1'b0, b_i}) : {1'b0, hi_i};
    div_shift = {hi_i, lo_i[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_i};
    div_ok    = ~div_diff[WIDTH];
    if (div_mode_i) begin
      hi_o = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], div_ok};
    end else begin
      hi_o = mul_sum[WIDTH:1];
      lo_o = {mul_sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers. Operand magnitudes are
// captured at the accepting edge, the unsigned core runs one bit per cycle,
// and the sign fix-up is applied combinationally in FIN where the result is
// presented on hi/lo together with done and written back at the FIN exit edge.
// Build option MULDIV_FAST_MUL_EN selects a single-cycle multiply.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  muldiv_unit_if.slave   md
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wh_q, wh_d;     // partial product high / remainder
  logic [WIDTH-1:0] wl_q, wl_d;     // multiplier+product low / dividend+quotient
  logic [WIDTH-1:0] wb_q, wb_d;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] araw_q, araw_d; // raw dividend, returned on divide by zero
  logic             neg_q, neg_d;   // product or quotient must be negated
  logic             negr_q, negr_d; // remainder must be negated
  logic             div0_q, div0_d;
  logic             isdiv_q, isdiv_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             accept_mul, accept_div, idle_req;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             fin_ok;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode_i (state_q == MD_S_DIV),
    .hi_i       (wh_q),
    .lo_i       (wl_q),
    .b_i        (wb_q),
    .hi_o       (step_hi),
    .lo_o       (step_lo)
  );

  // Operand decode: magnitudes and request qualification in IDLE
  always_comb begin
    a_neg      = is_signed_op(md.op) & md.src_a[WIDTH-1];
    b_neg      = is_signed_op(md.op) & md.src_b[WIDTH-1];
    mag_a      = a_neg ? -md.src_a : md.src_a;
    mag_b      = b_neg ? -md.src_b : md.src_b;
    idle_req   = (state_q == MD_S_IDLE) & md.start & ~md.flush;
    accept_mul = idle_req & is_mul_op(md.op);
    accept_div = idle_req & is_div_op(md.op);
  end

  // Sign fix-up and divide special cases, valid while in FIN
  always_comb begin
    prod_raw = {wh_q, wl_q};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    if (isdiv_q) begin
      if (div0_q) begin
        res_hi = araw_q;
        res_lo = '1;
      end else begin
        res_hi = negr_q ? -wh_q : wh_q;
        res_lo = neg_q ? -wl_q : wl_q;
      end
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  // FSM next-state, iteration counter, working and HI/LO register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    wb_d    = wb_q;
    araw_d  = araw_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    isdiv_d = isdiv_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MD_S_IDLE: begin
        if (accept_mul) begin
          state_d = MD_S_MUL;
          cnt_d   = CNT_INIT;
          wh_d    = '0;
          wl_d    = mag_b;
          wb_d    = mag_a;
          araw_d  = md.src_a;
          neg_d   = a_neg ^ b_neg;
          negr_d  = 1'b0;
          div0_d  = 1'b0;
          isdiv_d = 1'b0;
        end else if (accept_div) begin
          state_d = MD_S_DIV;
          cnt_d   = CNT_INIT;
          wh_d    = '0;
          wl_d    = mag_a;
          wb_d    = mag_b;
          araw_d  = md.src_a;
          neg_d   = a_neg ^ b_neg;
          negr_d  = a_neg;
          div0_d  = (md.src_b == '0);
          isdiv_d = 1'b1;
        end else if (idle_req && md.op == MD_MTHI) begin
          hi_d = md.src_a;
        end else if (idle_req && md.op == MD_MTLO) begin
          lo_d = md.src_a;
        end
      end
      MD_S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
        {wh_d, wl_d} = {{WIDTH{1'b0}}, wb_q} * {{WIDTH{1'b0}}, wl_q};
        state_d      = MD_S_FIN;
`else
        wh_d  = step_hi;
        wl_d  = step_lo;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = MD_S_FIN;
`endif
      end
      MD_S_DIV: begin
        wh_d  = step_hi;
        wl_d  = step_lo;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = MD_S_FIN;
      end
      MD_S_FIN: begin
        state_d = MD_S_IDLE;
        hi_d    = res_hi;
        lo_d    = res_lo;
      end
      default: state_d = MD_S_IDLE;
    endcase
    // A flush abandons any in-flight operation, including its FIN write-back
    if (md.flush && state_q != MD_S_IDLE) begin
      state_d = MD_S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_S_IDLE;
      cnt_q   <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      wb_q    <= '0;
      araw_q  <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      isdiv_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      wb_q    <= wb_d;
      araw_q  <= araw_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      isdiv_q <= isdiv_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs: the FIN result is shown alongside done unless flushed away
  always_comb begin
    fin_ok   = (state_q == MD_S_FIN) & ~md.flush;
    md.busy  = (state_q != MD_S_IDLE);
    md.done  = fin_ok;
    md.hi    = fin_ok ? res_hi : hi_q;
    md.lo    = fin_ok ? res_lo : lo_q;
    md.state = state_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (WIDTH=32): directed vector table, randomized ops
// against an arithmetic reference model, and hand-written flush/reset/MTHI/
// MTLO sequences. Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  logic [W-1:0] m_hi;  // expected architectural HI
  logic [W-1:0] m_lo;  // expected architectural LO

  muldiv_unit_if #(.WIDTH(W)) mif ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .md  (mif)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eh;
    logic [W-1:0] el;
    string        nm;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    p = '0;
    case (op)
      MD_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
      end
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          p  = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  // Issue one MULT/DIV and check latency, done pulse and result
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input string nm);
    int busy_cycles;
    int done_cycles;
    int exp_lat;
    logic [W-1:0] got_hi;
    logic [W-1:0] got_lo;
    exp_lat = is_mul_op(op) ? MUL_LAT : DIV_LAT;
    got_hi = 'x;
    got_lo = 'x;
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = op;
    mif.src_a = a;
    mif.src_b = b;
    @(negedge clk);
    mif.start = 1'b0;
    mif.src_a = $urandom;
    mif.src_b = $urandom;
    busy_cycles = 0;
    done_cycles = 0;
    while (mif.busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      if (mif.done === 1'b1) begin
        done_cycles++;
        got_hi = mif.hi;
        got_lo = mif.lo;
      end
      @(negedge clk);
    end
    check({nm, " latency"}, 64'(busy_cycles), 64'(exp_lat));
    check({nm, " done pulses"}, 64'(done_cycles), 64'd1);
    check({nm, " hi/lo at done"}, {got_hi, got_lo}, {eh, el});
    check({nm, " hi/lo held"}, {mif.hi, mif.lo}, {eh, el});
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t vecs[10];

  initial begin
    logic [63:0] exp;
    logic [2:0]  rop;
    logic [W-1:0] ra, rb;
    int          saw_done;
    int          guard;
    n_pass = 0;
    n_total = 0;
    mif.start = 1'b0;
    mif.op    = MD_MULT;
    mif.src_a = '0;
    mif.src_b = '0;
    mif.flush = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(mif.busy), 64'd0);
    check("reset done", 64'(mif.done), 64'd0);
    check("reset hi/lo", {mif.hi, mif.lo}, 64'd0);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;

    // Directed vectors
    vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7"};
    vecs[1] = '{MD_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        "divu 100/7"};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"};
    vecs[3] = '{MD_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, "divu 5/0"};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, "div ovf"};
    vecs[5] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max"};
    vecs[6] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, "div -5/0"};
    vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, "div 7/-2"};
    vecs[8] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        "mult minneg^2"};
    vecs[9] = '{MD_MULT,  32'd6,         32'd7,        32'd0,         32'd42,        "mult 6*7"};
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].nm);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = '1; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      exp = model(rop, ra, rb);
      run_op(rop, ra, rb, exp[63:32], exp[31:0], "random");
    end

    // Flush 10 cycles into a MULTU, then a DIVU right after
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = MD_MULTU;
    mif.src_a = '1;
    mif.src_b = '1;
    @(negedge clk);
    mif.start = 1'b0;
    saw_done = 0;
    repeat (9) begin
      @(negedge clk);
      if (mif.done === 1'b1) saw_done++;
    end
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    check("flush busy", 64'(mif.busy), 64'd0);
    check("flush hi/lo kept", {mif.hi, mif.lo}, {m_hi, m_lo});
    check("flush no done", 64'(saw_done), 64'd0);
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu after flush");

    // Flush in FIN discards the result
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = MD_DIVU;
    mif.src_a = 32'd50;
    mif.src_b = 32'd5;
    @(negedge clk);
    mif.start = 1'b0;
    guard = 0;
    while (mif.done !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("fin reached", 64'(guard < 100), 64'd1);
    mif.flush = 1'b1;
    #1;
    check("fin flush done", 64'(mif.done), 64'd0);
    @(negedge clk);
    mif.flush = 1'b0;
    check("fin flush busy", 64'(mif.busy), 64'd0);
    check("fin flush hi/lo", {mif.hi, mif.lo}, {m_hi, m_lo});

    // MTHI / MTLO in IDLE
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = MD_MTHI;
    mif.src_a = 32'h1234_5678;
    @(negedge clk);
    mif.start = 1'b0;
    check("mthi busy", 64'(mif.busy), 64'd0);
    check("mthi hi", 64'(mif.hi), 64'h1234_5678);
    m_hi = 32'h1234_5678;
    mif.start = 1'b1;
    mif.op    = MD_MTLO;
    mif.src_a = 32'hCAFE_F00D;
    @(negedge clk);
    mif.start = 1'b0;
    check("mtlo lo", {mif.hi, mif.lo}, {m_hi, 32'hCAFE_F00D});
    m_lo = 32'hCAFE_F00D;

    // Flush wins over MTHI; undefined op ignored
    mif.start = 1'b1;
    mif.op    = MD_MTHI;
    mif.src_a = 32'hDEAD_BEEF;
    mif.flush = 1'b1;
    @(negedge clk);
    mif.flush = 1'b0;
    mif.op    = 3'b110;
    @(negedge clk);
    mif.start = 1'b0;
    check("flush+mthi / undef op", {mif.hi, mif.lo}, {m_hi, m_lo});
    check("undef op busy", 64'(mif.busy), 64'd0);

    // MTLO while busy is ignored
    mif.start = 1'b1;
    mif.op    = MD_MULT;
    mif.src_a = 32'd6;
    mif.src_b = 32'd7;
    @(negedge clk);
    mif.op    = MD_MTLO;
    mif.src_a = 32'h5555_AAAA;
    @(negedge clk);
    mif.start = 1'b0;
    guard = 0;
    while (mif.busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("mtlo while busy", {mif.hi, mif.lo}, {32'd0, 32'd42});

    // Asynchronous reset mid-divide
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = MD_DIVU;
    mif.src_a = 32'd1000;
    mif.src_b = 32'd3;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid-div busy", 64'(mif.busy), 64'd0);
    check("rst mid-div done", 64'(mif.done), 64'd0);
    check("rst mid-div hi/lo", {mif.hi, mif.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0;
    m_lo = '0;
    run_op(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "mult after rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
